// File: rtl/pipeline_flow_types.sv
// Shared pipeline-register types for the EX/MEM and MEM/WB boundaries.
// Also holds the byte-lane helpers used by the memory stage.
package pipeline_flow_types;

    typedef enum logic [1:0] {
        MEMWIDTH_BYTE = 2'd0,
        MEMWIDTH_HALF = 2'd1,
        MEMWIDTH_WORD = 2'd2
    } mem_width_t;

    typedef struct packed {
        logic       MemRead;
        logic       MemWrite;
        mem_width_t MemWidth;
        logic       MemUnsigned;
    } mem_ctrl_t;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
    } wb_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [31:0] pc_incr;
        logic [31:0] pc_offset;
        logic [31:0] immediate;
        logic [4:0]  rd_addr;
        mem_ctrl_t   mem_ctrl;
        wb_ctrl_t    wb_ctrl;
    } ex_mem_flow_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] mem_data;
        logic [31:0] pc_incr;
        logic [31:0] pc_offset;
        logic [31:0] immediate;
        logic [4:0]  rd_addr;
        wb_ctrl_t    wb_ctrl;
        logic        mem_fault;
        logic        misaligned;
    } mem_wb_flow_t;

    function automatic logic is_misaligned(input mem_width_t width, input logic [1:0] off);
        logic mis;
        case (width)
            MEMWIDTH_BYTE: mis = 1'b0;
            MEMWIDTH_HALF: mis = off[0];
            default:       mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] lane_enables(input mem_width_t width, input logic [1:0] off);
        logic [3:0] be;
        case (width)
            MEMWIDTH_BYTE: be = 4'b0001 << off;
            MEMWIDTH_HALF: be = 4'b0011 << {off[1], 1'b0};
            default:       be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input mem_width_t width, input logic [31:0] rs2);
        logic [31:0] wd;
        case (width)
            MEMWIDTH_BYTE: wd = {4{rs2[7:0]}};
            MEMWIDTH_HALF: wd = {2{rs2[15:0]}};
            default:       wd = rs2;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/pipeline_ifs.sv
// Side-band interfaces from the memory stage to forwarding and hazard control.
interface forwarding_if;
    logic [4:0]  mem_rd_addr;
    logic        mem_RegWrite;
    logic [31:0] mem_data;

    modport mem_stage (output mem_rd_addr, output mem_RegWrite, output mem_data);
    modport forwarding_unit (input mem_rd_addr, input mem_RegWrite, input mem_data);
endinterface

interface hazard_if;
    logic Stall;

    modport mem_stage (output Stall);
    modport hazard_unit (input Stall);
endinterface

// File: rtl/mem_stage_load_extend.sv
// Load-data lane selection and sign/zero extension of a raw bus word.
module load_extend
    import pipeline_flow_types::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  byte_off,
    input  mem_width_t  width,
    input  logic        is_unsigned,
    output logic [31:0] data
);
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed lane, then extend it to a full word.
    always_comb begin
        case (byte_off)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        if (byte_off[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (width)
            MEMWIDTH_BYTE: data = is_unsigned ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
            MEMWIDTH_HALF: data = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            default:       data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: byte-lane req/ack transaction, load extension,
// wait watchdog and the MEM/WB pipeline register.
module mem_stage
    import pipeline_flow_types::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  ex_mem_flow_t inflow,
    output mem_wb_flow_t outflow,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [31:0]  dmem_addr,
    output logic [31:0]  dmem_wdata,
    output logic [3:0]   dmem_be,
    input  logic         dmem_ack,
    input  logic [31:0]  dmem_rdata,
    forwarding_if.mem_stage fd,
    hazard_if.mem_stage     hd
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic WDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t         state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    mem_wb_flow_t   outflow_r, outflow_s;
    logic           access_s, misaligned_s, bus_access_s, timeout_hit_s, stall_s;
    logic [31:0]    load_data_s;

    load_extend u_load_extend (
        .rdata       (dmem_rdata),
        .byte_off    (inflow.alu_result[1:0]),
        .width       (inflow.mem_ctrl.MemWidth),
        .is_unsigned (inflow.mem_ctrl.MemUnsigned),
        .data        (load_data_s)
    );

    // Access decode, bus fields and the stall the front of the pipe sees.
    always_comb begin
        access_s      = inflow.mem_ctrl.MemRead | inflow.mem_ctrl.MemWrite;
        misaligned_s  = access_s & is_misaligned(inflow.mem_ctrl.MemWidth, inflow.alu_result[1:0]);
        bus_access_s  = access_s & ~misaligned_s;
        timeout_hit_s = WDOG_EN & (state_r == ST_BUSY) & (cnt_r == CNT_LIMIT);
        stall_s       = bus_access_s & ~dmem_ack & ~timeout_hit_s;
        dmem_req      = ~rst & bus_access_s;
        dmem_we       = inflow.mem_ctrl.MemWrite;
        dmem_addr     = {inflow.alu_result[31:2], 2'b00};
        dmem_be       = lane_enables(inflow.mem_ctrl.MemWidth, inflow.alu_result[1:0]);
        dmem_wdata    = lane_data(inflow.mem_ctrl.MemWidth, inflow.rs2_data);
        hd.Stall      = stall_s;
    end

    // Forwarding sees the instruction currently occupying this stage.
    always_comb begin
        fd.mem_rd_addr  = inflow.rd_addr;
        fd.mem_RegWrite = inflow.wb_ctrl.RegWrite;
        fd.mem_data     = inflow.alu_result;
    end

    // IDLE/BUSY sequencing; the counter tracks wait cycles since the request.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (bus_access_s & ~dmem_ack) begin
                    state_s = ST_BUSY;
                    cnt_s   = WDOG_EN ? CNT_W'(1) : '0;
                end else begin
                    cnt_s   = '0;
                end
            end
            ST_BUSY: begin
                if (dmem_ack | timeout_hit_s | ~bus_access_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else if (WDOG_EN) begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end else begin
                    cnt_s   = cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Next MEM/WB contents: the completing instruction, or a bubble while stalled.
    always_comb begin
        outflow_s = '0;
        if (!stall_s) begin
            outflow_s.alu_result = inflow.alu_result;
            outflow_s.pc_incr    = inflow.pc_incr;
            outflow_s.pc_offset  = inflow.pc_offset;
            outflow_s.immediate  = inflow.immediate;
            outflow_s.rd_addr    = inflow.rd_addr;
            outflow_s.wb_ctrl    = inflow.wb_ctrl;
            if (misaligned_s) begin
                outflow_s.misaligned       = 1'b1;
                outflow_s.wb_ctrl.RegWrite = 1'b0;
            end else if (bus_access_s & ~dmem_ack) begin
                outflow_s.mem_fault        = 1'b1;
                outflow_s.wb_ctrl.RegWrite = 1'b0;
            end else if (bus_access_s & inflow.mem_ctrl.MemRead) begin
                outflow_s.mem_data = load_data_s;
            end else begin
                outflow_s.mem_data = 32'h0000_0000;
            end
        end else begin
            outflow_s = '0;
        end
    end

    // State, wait counter and MEM/WB register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            outflow_r <= '0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            outflow_r <= outflow_s;
        end
    end

    assign outflow = outflow_r;

endmodule

// File: tb/tb_mem_stage.sv
// Randomised self-checking bench for mem_stage against a transaction-level model.
module tb_mem_stage;
    import pipeline_flow_types::*;

    localparam int T = 4;

    logic         clk = 1'b0;
    logic         rst;
    ex_mem_flow_t inflow;
    mem_wb_flow_t outflow;
    logic         dmem_req, dmem_we, dmem_ack;
    logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]   dmem_be;
    int           checks = 0;
    int           errors = 0;

    forwarding_if fd_if ();
    hazard_if     hd_if ();

    mem_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .inflow     (inflow),
        .outflow    (outflow),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .fd         (fd_if),
        .hd         (hd_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // kind: 0 = no memory access, 1 = load, 2 = store
    function automatic ex_mem_flow_t mk(input int kind, input mem_width_t w, input logic uns,
                                        input logic [31:0] a, input logic [31:0] rs2,
                                        input logic [4:0] rd, input logic rw);
        ex_mem_flow_t f;
        f = '0;
        f.alu_result           = a;
        f.rs2_data             = rs2;
        f.pc_incr              = $urandom;
        f.pc_offset            = $urandom;
        f.immediate            = $urandom;
        f.rd_addr              = rd;
        f.mem_ctrl.MemRead     = (kind == 1);
        f.mem_ctrl.MemWrite    = (kind == 2);
        f.mem_ctrl.MemWidth    = w;
        f.mem_ctrl.MemUnsigned = uns;
        f.wb_ctrl.RegWrite     = rw;
        f.wb_ctrl.ResultSrc    = 2'($urandom_range(0, 3));
        return f;
    endfunction

    // lat: cycle index (0 = same cycle) at which ack is given; negative = never.
    task automatic run_txn(input ex_mem_flow_t ins, input int lat, input logic [31:0] rdata);
        logic         acc, mis, fault, uns;
        int           off, done_at;
        mem_width_t   w;
        logic [31:0]  sh, exp_wd, exp_ld;
        logic [7:0]   b8;
        logic [15:0]  h16;
        logic [3:0]   exp_be;
        mem_wb_flow_t exp_o;

        w     = ins.mem_ctrl.MemWidth;
        uns   = ins.mem_ctrl.MemUnsigned;
        acc   = ins.mem_ctrl.MemRead | ins.mem_ctrl.MemWrite;
        off   = int'(ins.alu_result[1:0]);
        mis   = acc && ((w == MEMWIDTH_HALF && (off % 2) != 0) || (w == MEMWIDTH_WORD && off != 0));
        fault = 1'b0;
        if (!acc || mis)                 done_at = 0;
        else if (lat >= 0 && lat <= T)   done_at = lat;
        else begin done_at = T; fault = 1'b1; end

        sh  = rdata >> (8 * off);
        b8  = sh[7:0];
        h16 = sh[15:0];
        case (w)
            MEMWIDTH_BYTE: begin
                exp_be = 4'(1 << off);
                exp_wd = 32'(ins.rs2_data[7:0]) * 32'h0101_0101;
                exp_ld = uns ? 32'(b8) : 32'($signed(b8));
            end
            MEMWIDTH_HALF: begin
                exp_be = 4'(3 << (off & 2));
                exp_wd = 32'(ins.rs2_data[15:0]) * 32'h0001_0001;
                exp_ld = uns ? 32'(h16) : 32'($signed(h16));
            end
            default: begin
                exp_be = 4'hF;
                exp_wd = ins.rs2_data;
                exp_ld = rdata;
            end
        endcase

        exp_o            = '0;
        exp_o.alu_result = ins.alu_result;
        exp_o.pc_incr    = ins.pc_incr;
        exp_o.pc_offset  = ins.pc_offset;
        exp_o.immediate  = ins.immediate;
        exp_o.rd_addr    = ins.rd_addr;
        exp_o.wb_ctrl    = ins.wb_ctrl;
        if (mis) begin
            exp_o.misaligned       = 1'b1;
            exp_o.wb_ctrl.RegWrite = 1'b0;
        end else if (fault) begin
            exp_o.mem_fault        = 1'b1;
            exp_o.wb_ctrl.RegWrite = 1'b0;
        end else if (ins.mem_ctrl.MemRead) begin
            exp_o.mem_data = exp_ld;
        end

        inflow     = ins;
        dmem_rdata = rdata;
        for (int c = 0; c <= done_at; c++) begin
            if (acc && !mis) dmem_ack = (c == lat);
            else             dmem_ack = !acc && ($urandom_range(0, 1) == 1);
            @(negedge clk);
            check_eq("req", 192'(dmem_req), 192'(acc && !mis));
            check_eq("stall", 192'(hd_if.Stall), 192'(c < done_at));
            check_eq("fwd_rd", 192'({fd_if.mem_RegWrite, fd_if.mem_rd_addr, fd_if.mem_data}),
                     192'({ins.wb_ctrl.RegWrite, ins.rd_addr, ins.alu_result}));
            if (acc && !mis) begin
                check_eq("addr", 192'(dmem_addr), 192'(ins.alu_result & 32'hFFFF_FFFC));
                check_eq("be", 192'(dmem_be), 192'(exp_be));
                check_eq("we", 192'(dmem_we), 192'(ins.mem_ctrl.MemWrite));
                if (ins.mem_ctrl.MemWrite) check_eq("wdata", 192'(dmem_wdata), 192'(exp_wd));
            end
            @(posedge clk);
            #1;
            if (c < done_at) check_eq("bubble", 192'(outflow), 192'(0));
            else             check_eq("outflow", 192'(outflow), 192'(exp_o));
        end
        dmem_ack = 1'b0;
    endtask

    initial begin
        ex_mem_flow_t ins, nop;
        mem_wb_flow_t exp_nop;
        int           kind;

        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0000_0000;
        inflow     = mk(1, MEMWIDTH_WORD, 1'b0, 32'h0000_0040, 32'h0, 5'd3, 1'b1);
        @(negedge clk);
        check_eq("req_in_reset", 192'(dmem_req), 192'(0));
        @(posedge clk);
        #1;
        check_eq("reset_outflow", 192'(outflow), 192'(0));
        rst = 1'b0;

        run_txn(mk(2, MEMWIDTH_WORD, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 1'b0), 0, 32'h0);
        run_txn(mk(2, MEMWIDTH_BYTE, 1'b0, 32'h0000_0103, 32'h0000_00AB, 5'd0, 1'b0), 0, 32'h0);
        run_txn(mk(1, MEMWIDTH_BYTE, 1'b0, 32'h0000_0102, 32'h0, 5'd7, 1'b1), 3, 32'h0080_FF00);
        run_txn(mk(1, MEMWIDTH_BYTE, 1'b1, 32'h0000_0102, 32'h0, 5'd8, 1'b1), 3, 32'h0080_FF00);
        run_txn(mk(1, MEMWIDTH_HALF, 1'b0, 32'h0000_0101, 32'h0, 5'd9, 1'b1), 0, 32'h1234_5678);
        run_txn(mk(1, MEMWIDTH_WORD, 1'b0, 32'h0000_0200, 32'h0, 5'd10, 1'b1), -1, 32'h5555_AAAA);
        run_txn(mk(1, MEMWIDTH_WORD, 1'b0, 32'h0000_0204, 32'h0, 5'd11, 1'b1), T, 32'hCAFE_F00D);
        run_txn(mk(1, MEMWIDTH_HALF, 1'b0, 32'h0000_0302, 32'h0, 5'd12, 1'b1), 1, 32'h8001_7FFF);

        // Reset while BUSY, with a stray ack the cycle after reset releases.
        inflow   = mk(1, MEMWIDTH_WORD, 1'b0, 32'h0000_0400, 32'h0, 5'd13, 1'b1);
        dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("req_rst_busy", 192'(dmem_req), 192'(0));
        @(posedge clk);
        #1;
        check_eq("rst_busy_outflow", 192'(outflow), 192'(0));
        rst      = 1'b0;
        nop      = mk(0, MEMWIDTH_WORD, 1'b0, 32'h0000_1234, 32'h0, 5'd14, 1'b1);
        inflow   = nop;
        dmem_ack = 1'b1;
        @(negedge clk);
        check_eq("late_ack_req", 192'(dmem_req), 192'(0));
        check_eq("late_ack_stall", 192'(hd_if.Stall), 192'(0));
        @(posedge clk);
        #1;
        exp_nop            = '0;
        exp_nop.alu_result = nop.alu_result;
        exp_nop.pc_incr    = nop.pc_incr;
        exp_nop.pc_offset  = nop.pc_offset;
        exp_nop.immediate  = nop.immediate;
        exp_nop.rd_addr    = nop.rd_addr;
        exp_nop.wb_ctrl    = nop.wb_ctrl;
        check_eq("late_ack_outflow", 192'(outflow), 192'(exp_nop));
        dmem_ack = 1'b0;
        run_txn(mk(1, MEMWIDTH_WORD, 1'b0, 32'h0000_0500, 32'h0, 5'd15, 1'b1), 3, 32'h0BAD_CAFE);

        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 2);
            ins  = mk(kind, mem_width_t'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                      $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            run_txn(ins, $urandom_range(0, T + 2), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, and the consumer of `ex_mem_flow_t`.
- Turns the EX result into a byte-lane data-memory transaction over a req/ack bus, and extends load data.
- Reports its destination register to forwarding and stalls the front of the pipe through `hazard_if` while a transaction is outstanding.
- Owns the MEM/WB pipeline register, so `outflow` is registered.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: wait cycles in BUSY before a forced fault completion; 0 disables the watchdog.

Ports:
- One clock; reset is synchronous and active-high.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  synchronous reset.
- `inflow`  in  `ex_mem_flow_t`  EX/MEM register contents.
- `outflow`  out  `mem_wb_flow_t`  registered MEM/WB contents: alu_result, mem_data, pc_incr, pc_offset, immediate, rd_addr, wb_ctrl, mem_fault, misaligned.
- `dmem_req`  out  1  transaction request.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  32  word-aligned address.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_be`  out  4  byte enables.
- `dmem_ack`  in  1  completion; rdata valid this cycle.
- `dmem_rdata`  in  32  raw word read.
- `fd`  `forwarding_if.mem_stage`  drives rd_addr, RegWrite and data.mem = inflow.alu_result.
- `hd`  `hazard_if.mem_stage`  drives Stall.

## Operation
- Access = mem_ctrl.MemRead | mem_ctrl.MemWrite. Address a = inflow.alu_result.
- Width comes from mem_ctrl.MemWidth (BYTE/HALF/WORD); mem_ctrl.MemUnsigned selects zero-extension for loads.
- Misaligned access: HALF with a[0]=1, or WORD with a[1:0]≠0.
  - No bus request is made.
  - Completes in one cycle with outflow.misaligned=1 and wb_ctrl.RegWrite forced 0.
- Bus fields:
  - dmem_addr = {a[31:2],2'b00}.
  - BYTE: be=4'b0001<<a[1:0], wdata={4{rs2[7:0]}}.
  - HALF: be=4'b0011<<{a[1],1'b0}, wdata={2{rs2[15:0]}}.
  - WORD: be=4'b1111, wdata=rs2_data.
  - Loads drive the same be; dmem_we=MemWrite.
- Load data: select the lane by a[1:0], then sign- or zero-extend to 32 bits.
- FSM states IDLE and BUSY:
  - IDLE with an aligned access: dmem_req=1 combinationally. ack in the same cycle completes with zero wait. No ack → BUSY.
  - BUSY: dmem_req=1 and the wait counter increments. ack → complete, back to IDLE. Counter reaching TIMEOUT_CYCLES (nonzero) → fault completion: mem_data=0, mem_fault=1, RegWrite forced 0, back to IDLE.
  - Non-access instructions pass through IDLE in one cycle.
- hd.Stall = access & aligned & ~ack & ~timeout_hit, for the current cycle.
- Upstream holds inflow stable while Stall is high, so request fields stay stable until ack.
- On every clock, the MEM/WB register takes one of:
  - the completed instruction;
  - a bubble (wb_ctrl.RegWrite=0, mem_ctrl-derived flags 0, other fields 0) while Stall=1.

## Timing
- Reset: state=IDLE, counter=0, outflow=all zero (bubble). dmem_req is forced 0 during any cycle with rst=1.
- Zero-wait memory: 1 cycle, no stall. N wait cycles: N stall cycles; the result appears in outflow on the edge after ack.
- ack arrives only while req is high. ack seen in IDLE without an access is ignored.
- ack on the same cycle the timeout count is reached: ack wins and completes normally.
- Reset in BUSY: the transaction is abandoned, and a late ack after reset is ignored.
- Counter clears on every completion. Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.

## Structure
- Add to `pipeline_flow_types.sv`: `mem_wb_flow_t`, and the MemWidth enum `MEMWIDTH_BYTE/HALF/WORD`.
- The FSM state enum stays local.
- Sub-module `load_extend`: combinational lane select and extension from (rdata, a[1:0], width, unsigned).

## Test plan
- SW a=0x100, rs2=0xDEADBEEF, ack same cycle → be=1111, addr=0x100, no stall; outflow.rd_addr=0, RegWrite=0 next cycle.
- SB a=0x103, rs2=0x000000AB → be=1000, wdata=0xABABABAB.
- LB a=0x102, rdata=0x0080FF00, ack after 3 cycles → Stall high for 3 cycles, 3 bubbles out, then mem_data=0xFFFFFF80. Same with LBU → 0x00000080.
- LH a=0x101 → no req, misaligned=1, RegWrite=0, no stall.
- TIMEOUT_CYCLES=4, LW never acked → Stall for 4 cycles, then mem_fault=1, mem_data=0, RegWrite=0, IDLE.
- rst asserted in BUSY with ack arriving the next cycle → outflow bubble, state IDLE, ack ignored, req=0 during reset.
